// File: rtl/sh2_bus_arbiter.sv
// Purpose: shares the master SH-2 external bus between the slave SH-2 and the SCU DMA engine.
// Latency: request->BRLS_N one CE_R tick, BGR_N->ack one tick, release->ack/BRLS_N high one tick.
// Backpressure: the winner holds the bus until it releases; the loser waits, and the turnaround gap throttles the next tenure.
module sh2_bus_arbiter #(
  parameter int ARB_MODE   = 0,
  parameter int GAP_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       RES_N,
  input  logic       BREQ_N,
  input  logic       EXBREQ_N,
  input  logic       BGR_N,
  output logic       BRLS_N,
  output logic       BACK_N,
  output logic       EXBACK_N,
  output logic [1:0] OWNER,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    REQR_SSH = 1'b0,
    REQR_SCU = 1'b1
  } reqr_t;

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);
  localparam logic [1:0] OWN_MSH  = 2'd0;
  localparam logic [1:0] OWN_SSH  = 2'd1;
  localparam logic [1:0] OWN_SCU  = 2'd2;

  state_t     state_q, state_d;
  reqr_t      win_q, win_d;
  reqr_t      last_q, last_d;
  logic [3:0] gap_q, gap_d;
  logic       brls_n_q, brls_n_d;
  logic       back_n_q, back_n_d;
  logic       exback_n_q, exback_n_d;
  logic [1:0] owner_q, owner_d;

  logic ssh_req;
  logic scu_req;
  logic win_req;

  assign ssh_req = ~BREQ_N;
  assign scu_req = ~EXBREQ_N;
  // Request line of whichever requester currently holds or is waiting for the bus.
  assign win_req = (win_q == REQR_SCU) ? scu_req : ssh_req;

  // Next-state and registered-output computation; nothing moves on ticks without CE_R.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    gap_d      = gap_q;
    brls_n_d   = brls_n_q;
    back_n_d   = back_n_q;
    exback_n_d = exback_n_q;
    owner_d    = owner_q;

    if (CE_R) begin
      if (!RES_N) begin
        // Soft reset drops everything at once, without the turnaround gap.
        state_d    = ST_IDLE;
        win_d      = REQR_SSH;
        last_d     = REQR_SCU;
        gap_d      = 4'd0;
        brls_n_d   = 1'b1;
        back_n_d   = 1'b1;
        exback_n_d = 1'b1;
        owner_d    = OWN_MSH;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ssh_req || scu_req) begin
              if (ssh_req && scu_req) begin
                if (ARB_MODE == 0) begin
                  win_d = REQR_SCU;
                end else begin
                  win_d = (last_q == REQR_SCU) ? REQR_SSH : REQR_SCU;
                end
              end else begin
                win_d = scu_req ? REQR_SCU : REQR_SSH;
              end
              brls_n_d = 1'b0;
              state_d  = ST_REQ;
            end
          end

          ST_REQ: begin
            // A withdrawn request wins over a grant arriving on the same tick.
            if (!win_req) begin
              brls_n_d = 1'b1;
              gap_d    = GAP_INIT;
              state_d  = ST_DRAIN;
            end else if (!BGR_N) begin
              back_n_d   = (win_q == REQR_SCU);
              exback_n_d = (win_q == REQR_SSH);
              owner_d    = (win_q == REQR_SCU) ? OWN_SCU : OWN_SSH;
              last_d     = win_q;
              state_d    = ST_GRANT;
            end
          end

          ST_GRANT: begin
            // Only the owner's release ends the tenure; BGR_N and the loser are ignored.
            if (!win_req) begin
              back_n_d   = 1'b1;
              exback_n_d = 1'b1;
              brls_n_d   = 1'b1;
              owner_d    = OWN_MSH;
              gap_d      = GAP_INIT;
              state_d    = ST_DRAIN;
            end
          end

          ST_DRAIN: begin
            // Count out the idle gap, then wait for the master to take its bus back.
            if (gap_q != 4'd0) begin
              gap_d = gap_q - 4'd1;
            end else if (BGR_N) begin
              state_d = ST_IDLE;
            end
          end

          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      win_q      <= REQR_SSH;
      last_q     <= REQR_SCU;
      gap_q      <= 4'd0;
      brls_n_q   <= 1'b1;
      back_n_q   <= 1'b1;
      exback_n_q <= 1'b1;
      owner_q    <= OWN_MSH;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      brls_n_q   <= brls_n_d;
      back_n_q   <= back_n_d;
      exback_n_q <= exback_n_d;
      owner_q    <= owner_d;
    end
  end

  assign BRLS_N   = brls_n_q;
  assign BACK_N   = back_n_q;
  assign EXBACK_N = exback_n_q;
  assign OWNER    = owner_q;
  assign BUSY     = (state_q != ST_IDLE);

endmodule
